// File: rtl/gridx_power_pkg.sv
// Shared types for the gridx SRAM bank power path: power-state encodings,
// the wake sequencer FSM states and the width of its event counters.
package gridx_power_pkg;

    typedef enum logic [1:0] {
        PWR_SLEEP  = 2'b00,
        PWR_IDLE   = 2'b01,
        PWR_ACTIVE = 2'b10
    } pwr_state_e;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_WAKE,
        SEQ_SETTLE,
        SEQ_RELOAD_REQ,
        SEQ_RELOAD_WAIT,
        SEQ_GRANT
    } seq_state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/bank_wake_sequencer_if.sv
// Tile-buffer request / SRAM grant bundle. The tile buffer is the master;
// the wake sequencer is the slave that accepts requests and issues grants.
interface bank_wake_sequencer_if #(
    parameter int BANK_SEL_W = 3,
    parameter int ADDR_W     = 16
);

    logic                  req_valid;
    logic                  req_ready;
    logic [BANK_SEL_W-1:0] req_bank;
    logic [ADDR_W-1:0]     req_addr;

    logic                  grant_valid;
    logic [BANK_SEL_W-1:0] grant_bank;
    logic [ADDR_W-1:0]     grant_addr;
    logic                  grant_err;

    modport master (
        output req_valid, req_bank, req_addr,
        input  req_ready, grant_valid, grant_bank, grant_addr, grant_err
    );

    modport slave (
        input  req_valid, req_bank, req_addr,
        output req_ready, grant_valid, grant_bank, grant_addr, grant_err
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a long run
// never makes the wake/reload statistics look small again.
module sat_counter
    import gridx_power_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/bank_wake_sequencer.sv
// Holds a tile-buffer access to a gated or slept SRAM bank until the bank is
// powered and, if its contents were lost, reloaded by DMA; then grants it.
module bank_wake_sequencer
    import gridx_power_pkg::*;
#(
    parameter int NUM_BANKS    = 8,
    parameter int BANK_SEL_W   = 3,
    parameter int ADDR_W       = 16,
    parameter int WAKE_CYCLES  = 4,
    parameter int WAKE_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    bank_wake_sequencer_if.slave  req_if,

    input  logic [NUM_BANKS-1:0]  bank_power_enable,
    input  logic [NUM_BANKS-1:0]  bank_needs_reload,
    output logic [NUM_BANKS-1:0]  bank_active,
    output logic [NUM_BANKS-1:0]  force_enable,

    output logic                  reload_req_valid,
    output logic [BANK_SEL_W-1:0] reload_req_bank,
    input  logic                  reload_req_ready,
    input  logic                  reload_done,

    output logic [CNT_W-1:0]      wake_count,
    output logic [CNT_W-1:0]      reload_count
);

    localparam int TMR_MAX = (WAKE_TIMEOUT > WAKE_CYCLES) ? WAKE_TIMEOUT : WAKE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    seq_state_e            state_q, state_d;
    logic [BANK_SEL_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  err_q, err_d;
    logic                  bad_bank_q, bad_bank_d;
    logic                  reload_pending_q, reload_pending_d;
    logic                  was_asleep_q, was_asleep_d;
    logic [TMR_W-1:0]      timer_q, timer_d;

    logic                  wake_inc;
    logic                  reload_inc;

    logic [NUM_BANKS-1:0]  req_onehot;
    logic [NUM_BANKS-1:0]  cur_onehot;
    logic                  req_bad;
    logic                  req_enabled;
    logic                  req_lost;
    logic                  cur_enabled;
    logic                  cur_lost;
    logic                  settle_done;
    logic                  wake_expired;

    // Out-of-range bank selects shift the one-hot to zero, so they never
    // touch the power controller.
    assign req_onehot   = NUM_BANKS'(1) << req_if.req_bank;
    assign cur_onehot   = NUM_BANKS'(1) << bank_q;
    assign req_bad      = int'(req_if.req_bank) >= NUM_BANKS;
    assign req_enabled  = |(bank_power_enable & req_onehot);
    assign req_lost     = |(bank_needs_reload & req_onehot);
    assign cur_enabled  = |(bank_power_enable & cur_onehot);
    assign cur_lost     = |(bank_needs_reload & cur_onehot);
    assign settle_done  = !was_asleep_q || (timer_q == TMR_W'(WAKE_CYCLES - 1));
    assign wake_expired = (timer_q == TMR_W'(WAKE_TIMEOUT - 1));

    always_comb begin
        state_d          = state_q;
        bank_d           = bank_q;
        addr_d           = addr_q;
        err_d            = err_q;
        bad_bank_d       = bad_bank_q;
        reload_pending_d = reload_pending_q;
        was_asleep_d     = was_asleep_q;
        timer_d          = timer_q;
        wake_inc         = 1'b0;
        reload_inc       = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (req_if.req_valid) begin
                    bank_d           = req_if.req_bank;
                    addr_d           = req_if.req_addr;
                    bad_bank_d       = req_bad;
                    err_d            = req_bad;
                    reload_pending_d = req_lost;
                    was_asleep_d     = !req_enabled && req_lost;
                    timer_d          = '0;
                    if (req_bad || (req_enabled && !req_lost)) begin
                        state_d = SEQ_GRANT;
                    end else begin
                        state_d  = SEQ_WAKE;
                        wake_inc = 1'b1;
                    end
                end
            end

            // The controller drops needs_reload one cycle after re-enabling,
            // so the flag is accumulated rather than sampled once.
            SEQ_WAKE: begin
                reload_pending_d = reload_pending_q || cur_lost;
                timer_d          = timer_q + TMR_W'(1);
                if (cur_enabled) begin
                    timer_d = '0;
                    state_d = reload_pending_d ? SEQ_SETTLE : SEQ_GRANT;
                end else if (wake_expired) begin
                    err_d   = 1'b1;
                    state_d = SEQ_GRANT;
                end
            end

            SEQ_SETTLE: begin
                timer_d = timer_q + TMR_W'(1);
                if (settle_done) begin
                    state_d = SEQ_RELOAD_REQ;
                end
            end

            SEQ_RELOAD_REQ: begin
                if (reload_req_ready) begin
                    state_d = SEQ_RELOAD_WAIT;
                end
            end

            SEQ_RELOAD_WAIT: begin
                if (reload_done) begin
                    reload_inc = 1'b1;
                    state_d    = SEQ_GRANT;
                end
            end

            SEQ_GRANT: begin
                state_d = SEQ_IDLE;
            end

            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= SEQ_IDLE;
            bank_q           <= '0;
            addr_q           <= '0;
            err_q            <= 1'b0;
            bad_bank_q       <= 1'b0;
            reload_pending_q <= 1'b0;
            was_asleep_q     <= 1'b0;
            timer_q          <= '0;
        end else begin
            state_q          <= state_d;
            bank_q           <= bank_d;
            addr_q           <= addr_d;
            err_q            <= err_d;
            bad_bank_q       <= bad_bank_d;
            reload_pending_q <= reload_pending_d;
            was_asleep_q     <= was_asleep_d;
            timer_q          <= timer_d;
        end
    end

    // force_enable covers the whole reload window so a slow DMA cannot let
    // the bank fall back to idle before the data is restored.
    always_comb begin
        req_if.req_ready   = (state_q == SEQ_IDLE);
        req_if.grant_valid = (state_q == SEQ_GRANT);
        req_if.grant_bank  = (state_q == SEQ_GRANT) ? bank_q : '0;
        req_if.grant_addr  = (state_q == SEQ_GRANT) ? addr_q : '0;
        req_if.grant_err   = (state_q == SEQ_GRANT) && err_q;

        bank_active = '0;
        if ((state_q != SEQ_IDLE) && !bad_bank_q) begin
            bank_active = cur_onehot;
        end

        force_enable = '0;
        if ((state_q == SEQ_SETTLE) || (state_q == SEQ_RELOAD_REQ) ||
            (state_q == SEQ_RELOAD_WAIT)) begin
            force_enable = cur_onehot;
        end

        reload_req_valid = (state_q == SEQ_RELOAD_REQ);
        reload_req_bank  = (state_q == SEQ_RELOAD_REQ) ? bank_q : '0;
    end

    sat_counter #(.WIDTH(CNT_W)) u_wake_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (wake_inc),
        .count (wake_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_reload_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (reload_inc),
        .count (reload_count)
    );

endmodule
